// File: rtl/axi4_arb_pkg.sv
// Shared definitions for the AXI4 write-path round-robin arbiter:
// FSM state encoding and a width helper for the counters.
package axi4_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/axi4_arbiter_w_rr_if.sv
// Request/grant bundle between the write-path muxes and the arbiter.
// The master modport is the fabric side that drives requests; the slave
// modport is the arbiter side that returns the grant and AW enable.
interface axi4_arbiter_w_rr_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] s_AWVALID;
  logic [NUM_MASTERS-1:0] s_BREADY;
  logic                   m_AWREADY;
  logic                   m_BVALID;
  logic [NUM_MASTERS-1:0] m_WGRNT;
  logic                   m_AWEN;

  modport master (
    output s_AWVALID, s_BREADY, m_AWREADY, m_BVALID,
    input  m_WGRNT, m_AWEN
  );

  modport slave (
    input  s_AWVALID, s_BREADY, m_AWREADY, m_BVALID,
    output m_WGRNT, m_AWEN
  );
endinterface

// File: rtl/axi4_arbiter_w_rr_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after `start`, searching upward with wrap-around.
module rr_pick
  import axi4_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IW          = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          start,
  output logic [NUM_MASTERS-1:0] onehot,
  output logic [IW-1:0]          idx,
  output logic                   found
);

  logic [IW-1:0]          cand_idx [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] cand_req;

  // Candidate gi is the master sitting gi places after the start pointer.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, start} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(NUM_MASTERS))
                          ? IW'(sum - (IW+1)'(NUM_MASTERS)) : IW'(sum);
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Lowest offset wins: scan from the far end so nearer candidates overwrite.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        idx   = cand_idx[i];
        found = 1'b1;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/axi4_arbiter_w_rr.sv
// Round-robin arbiter for the AXI4 write path. Holds the grant until all
// bursts accepted in a tenure have completed their B handshake, throttles
// AW with m_AWEN once MAX_OUTSTANDING bursts are in flight, and rotates the
// search pointer on every release with zero-bubble re-arbitration.
// Optional feature: define AXI4_ARB_W_FAIRNESS_LIMIT_EN to cap each tenure
// at MAX_BURSTS AW handshakes.
module axi4_arbiter_w_rr
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_BURSTS      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  axi4_arbiter_w_rr_if.slave  bus
);

  localparam int IW = clog2(NUM_MASTERS);
  localparam int CW = clog2(MAX_OUTSTANDING + 1);

  if (NUM_MASTERS < 2 || MAX_OUTSTANDING < 1 || MAX_BURSTS < 1) begin : g_param_check
    $error("axi4_arbiter_w_rr: illegal parameter values");
  end

  logic [0:0]             state_reg, state_next;
  logic [IW-1:0]          g_reg, g_next;
  logic [IW-1:0]          ptr_reg, ptr_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [CW-1:0]          cnt_reg, cnt_next;

  logic                   busy, awen, aw_hs, b_hs, release_now, grant_load;
  logic                   burst_ok, budget_spent;
  logic [IW-1:0]          ptr_after;
  logic [NUM_MASTERS-1:0] idle_onehot, rel_onehot;
  logic [IW-1:0]          idle_idx, rel_idx;
  logic                   idle_found, rel_found;

  assign busy      = (state_reg == ST_BUSY);
  assign awen      = busy & (cnt_reg < CW'(MAX_OUTSTANDING)) & burst_ok;
  assign aw_hs     = busy & bus.s_AWVALID[g_reg] & awen & bus.m_AWREADY;
  assign b_hs      = busy & bus.m_BVALID & bus.s_BREADY[g_reg];
  assign ptr_after = (g_reg == IW'(NUM_MASTERS - 1)) ? '0 : g_reg + 1'b1;

  // A tenure ends when its last burst completes, when the master stops
  // requesting with nothing in flight, or when its burst budget is spent.
  assign release_now = busy & (((cnt_reg == CW'(1)) & b_hs & ~aw_hs)
                             | ((cnt_reg == '0) & ~bus.s_AWVALID[g_reg])
                             | budget_spent);

  assign bus.m_WGRNT = grant_reg;
  assign bus.m_AWEN  = awen;

  // Arbitration from the stored pointer while idle.
  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick_idle (
    .req    (bus.s_AWVALID),
    .start  (ptr_reg),
    .onehot (idle_onehot),
    .idx    (idle_idx),
    .found  (idle_found)
  );

  // Arbitration from the advanced pointer in the release cycle; the
  // outgoing master is searched last, so it only wins when alone.
  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick_rel (
    .req    (bus.s_AWVALID),
    .start  (ptr_after),
    .onehot (rel_onehot),
    .idx    (rel_idx),
    .found  (rel_found)
  );

`ifdef AXI4_ARB_W_FAIRNESS_LIMIT_EN
  localparam int BW = clog2(MAX_BURSTS + 1);
  logic [BW-1:0] burst_reg, burst_next;

  assign burst_ok     = (burst_reg < BW'(MAX_BURSTS));
  assign budget_spent = ~burst_ok & (cnt_reg == '0);
  assign burst_next   = grant_load ? '0 : (aw_hs ? burst_reg + 1'b1 : burst_reg);

  // Per-tenure AW count; restarts whenever a new grant is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) burst_reg <= '0;
    else        burst_reg <= burst_next;
  end
`else
  assign burst_ok     = 1'b1;
  assign budget_spent = 1'b0;
`endif

  // Next-state logic: outstanding counter, grant hand-over and pointer update.
  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    grant_load = 1'b0;
    cnt_next   = cnt_reg;
    if (aw_hs & ~b_hs)                         cnt_next = cnt_reg + 1'b1;
    else if (b_hs & ~aw_hs & (cnt_reg != '0))  cnt_next = cnt_reg - 1'b1;
    if (!busy) begin
      if (idle_found) begin
        state_next = ST_BUSY;
        g_next     = idle_idx;
        grant_next = idle_onehot;
        grant_load = 1'b1;
      end
    end else if (release_now) begin
      ptr_next = ptr_after;
      cnt_next = '0;
      if (rel_found) begin
        g_next     = rel_idx;
        grant_next = rel_onehot;
        grant_load = 1'b1;
      end else begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      g_reg     <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A B handshake with nothing outstanding means the slave side is broken.
  always_ff @(posedge clk) begin
    if (rst_n && b_hs) assert (cnt_reg != '0);
  end

endmodule

// File: tb/tb_axi4_arbiter_w_rr.sv
// Self-checking bench for axi4_arbiter_w_rr (NUM_MASTERS=4,
// MAX_OUTSTANDING=2, MAX_BURSTS=3). A tenure-level reference model
// (owner, in-flight count, pointer, burst budget) predicts grant and AWEN.
module tb_axi4_arbiter_w_rr;
  import axi4_arb_pkg::*;

  localparam int N  = 4;
  localparam int MO = 2;
  localparam int MB = 3;
`ifdef AXI4_ARB_W_FAIRNESS_LIMIT_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_arbiter_w_rr_if #(.NUM_MASTERS(N)) bus ();

  axi4_arbiter_w_rr #(
    .NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .MAX_BURSTS(MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model state
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_bursts = 0;
  bit m_aw, m_b;

  // Stimulus-side slave: per-master burst quotas (-1 = endless) and B due times
  int quota [N];
  int b_due [$];
  int b_delay = 2;
  bit b_hold  = 0;

  function automatic int pick(input logic [N-1:0] req, input int start);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (start + i) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_awen();
    return (m_owner >= 0) && (m_cnt < MO) && (!FAIR || m_bursts < MB);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) bus.s_AWVALID[i] = (quota[i] != 0);
    bus.m_BVALID = 1'b0;
    if (!b_hold && b_due.size() > 0) begin
      if (b_due[0] <= cyc) bus.m_BVALID = 1'b1;
    end
    bus.s_BREADY = '1;
  endtask

  // Advance the model by the current inputs, then step one clock.
  task automatic tick();
    logic [N-1:0] req;
    int w, prev;
    bit aw, b, rel;
    req  = bus.s_AWVALID;
    prev = m_owner;
    aw   = (m_owner >= 0) && req[m_owner] && exp_awen() && bus.m_AWREADY;
    b    = (m_owner >= 0) && bus.m_BVALID && bus.s_BREADY[m_owner];
    m_aw = aw;
    m_b  = b;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_bursts = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_cnt = 0; m_bursts = 0; end
    end else begin
      rel = (m_cnt == 1 && b && !aw) || (m_cnt == 0 && !req[m_owner])
            || (FAIR && m_bursts >= MB && m_cnt == 0);
      if (rel) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = pick(req, m_ptr);
        m_cnt = 0;
        m_bursts = 0;
      end else begin
        m_cnt = m_cnt + (aw ? 1 : 0) - ((b && m_cnt > 0) ? 1 : 0);
        m_bursts = m_bursts + (aw ? 1 : 0);
      end
    end
    if (aw) begin
      if (quota[prev] > 0) quota[prev]--;
      b_due.push_back(cyc + b_delay);
    end
    if (b && b_due.size() > 0) void'(b_due.pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) quota[i] = 0;
    b_due.delete();
    b_hold = 0;
    b_delay = 2;
    bus.m_AWREADY = 1'b0;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) quota[i] = -1;
    bus.m_AWREADY = 1'b0;
    drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.m_WGRNT !== 4'b0000) $display("FAIL reset_grant cyc=%0d got=%b want=0000", cyc, bus.m_WGRNT);
      else passed++;
      total++;
      if (bus.m_AWEN !== 1'b0) $display("FAIL reset_awen cyc=%0d got=%b want=0", cyc, bus.m_AWEN);
      else passed++;
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.m_WGRNT !== 4'b0001) $display("FAIL reset_first_grant got=%b want=0001", bus.m_WGRNT);
    else passed++;
    total++;
    if (bus.m_AWEN !== 1'b1) $display("FAIL reset_first_awen got=%b want=1", bus.m_AWEN);
    else passed++;
    for (int i = 0; i < N; i++) quota[i] = 0;
    drive();
    tick();
    total++;
    if (bus.m_WGRNT !== exp_grant()) $display("FAIL reset_drop got=%b want=%b", bus.m_WGRNT, exp_grant());
    else passed++;
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [$];
    logic [N-1:0] prev;
    int gap;
    do_reset();
    quota[1] = 1;
    quota[3] = 1;
    b_delay = 2;
    bus.m_AWREADY = 1'b1;
    prev = '0;
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      drive();
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL rot_grant cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      total++;
      if (bus.m_AWEN !== exp_awen()) $display("FAIL rot_awen cyc=%0d got=%b want=%b", cyc, bus.m_AWEN, exp_awen());
      else passed++;
      if (bus.m_WGRNT != 0 && bus.m_WGRNT != prev) seq.push_back(bus.m_WGRNT);
      if (seq.size() == 1 && bus.m_WGRNT == 0) gap++;
      prev = bus.m_WGRNT;
      tick();
    end
    total++;
    if (seq.size() != 2) $display("FAIL rot_count got=%0d grants want=2", seq.size());
    else begin
      if (seq[0] !== 4'b0010 || seq[1] !== 4'b1000)
        $display("FAIL rot_order got=%b,%b want=0010,1000", seq[0], seq[1]);
      else passed++;
    end
    total++;
    if (gap != 0) $display("FAIL rot_bubble got=%0d idle cycles want=0", gap);
    else passed++;
  endtask

  task automatic test_outstanding_limit();
    int aws;
    do_reset();
    quota[0] = -1;
    bus.m_AWREADY = 1'b1;
    b_hold = 1;
    b_delay = 1;
    aws = 0;
    for (int c = 0; c < 6; c++) begin
      drive();
      total++;
      if (bus.m_AWEN !== exp_awen()) $display("FAIL lim_awen cyc=%0d got=%b want=%b", cyc, bus.m_AWEN, exp_awen());
      else passed++;
      if (bus.m_AWEN && bus.s_AWVALID[0] && bus.m_AWREADY && bus.m_WGRNT[0]) aws++;
      tick();
    end
    total++;
    if (aws != 2) $display("FAIL lim_aw_count got=%0d want=2", aws);
    else passed++;
    total++;
    if (bus.m_AWEN !== 1'b0) $display("FAIL lim_full_awen got=%b want=0", bus.m_AWEN);
    else passed++;
    b_hold = 0;
    drive();
    tick();
    b_hold = 1;
    drive();
    total++;
    if (bus.m_AWEN !== 1'b1) $display("FAIL lim_reopen_awen got=%b want=1", bus.m_AWEN);
    else passed++;
    total++;
    if (bus.m_WGRNT !== 4'b0001) $display("FAIL lim_grant_kept got=%b want=0001", bus.m_WGRNT);
    else passed++;
    tick();
    quota[0] = 0;
    b_hold = 0;
    for (int c = 0; c < 8; c++) begin
      drive();
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL lim_drain cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      tick();
    end
  endtask

  task automatic test_simultaneous();
    int both;
    do_reset();
    quota[0] = -1;
    bus.m_AWREADY = 1'b1;
    b_delay = 1;
    both = 0;
    for (int c = 0; c < 8; c++) begin
      drive();
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL sim_grant cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      total++;
      if (bus.m_AWEN !== exp_awen()) $display("FAIL sim_awen cyc=%0d got=%b want=%b", cyc, bus.m_AWEN, exp_awen());
      else passed++;
      if (bus.m_AWEN && bus.s_AWVALID[0] && bus.m_AWREADY && bus.m_BVALID && bus.m_WGRNT[0]) both++;
      tick();
    end
    total++;
    if (both != 6) $display("FAIL sim_count got=%0d want=6", both);
    else passed++;
    total++;
    if (bus.m_WGRNT !== 4'b0001 || bus.m_AWEN !== 1'b1)
      $display("FAIL sim_stable got=%b/%b want=0001/1", bus.m_WGRNT, bus.m_AWEN);
    else passed++;
    quota[0] = 0;
    drive();
    tick();
    total++;
    if (bus.m_WGRNT !== 4'b0000) $display("FAIL sim_release got=%b want=0000", bus.m_WGRNT);
    else passed++;
  endtask

  task automatic test_fairness();
    logic [N-1:0] after2;
    bit seen, model_done;
    int obs, exp_n;
    do_reset();
    quota[2] = -1;
    drive();
    tick();
    quota[0] = -1;
    bus.m_AWREADY = 1'b1;
    b_delay = 2;
    after2 = 4'b0100;
    seen = 0;
    model_done = 0;
    obs = 0;
    exp_n = 0;
    for (int c = 0; c < 24; c++) begin
      drive();
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL fair_grant cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      if (!seen) begin
        if (bus.m_WGRNT !== 4'b0100) begin
          seen = 1;
          after2 = bus.m_WGRNT;
        end else if (bus.m_AWEN && bus.s_AWVALID[2] && bus.m_AWREADY) obs++;
      end
      if (!model_done) begin
        if (m_owner != 2) model_done = 1;
        else if (exp_awen() && bus.s_AWVALID[2] && bus.m_AWREADY) exp_n++;
      end
      tick();
    end
    total++;
    if (after2 !== (FAIR ? 4'b0001 : 4'b0100)) $display("FAIL fair_handover got=%b want=%b", after2, FAIR ? 4'b0001 : 4'b0100);
    else passed++;
    total++;
    if (obs != exp_n) $display("FAIL fair_bursts got=%0d want=%0d", obs, exp_n);
    else passed++;
    for (int i = 0; i < N; i++) quota[i] = 0;
    for (int c = 0; c < 16; c++) begin
      drive();
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL fair_drain cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      tick();
    end
  endtask

  task automatic test_lone_requester();
    do_reset();
    bus.s_AWVALID = 4'b0001;
    bus.s_BREADY = '1;
    bus.m_BVALID = 1'b0;
    bus.m_AWREADY = 1'b1;
    tick();
    tick();
    bus.m_AWREADY = 1'b0;
    bus.m_BVALID = 1'b1;
    total++;
    if (bus.m_WGRNT !== 4'b0001) $display("FAIL lone_first got=%b want=0001", bus.m_WGRNT);
    else passed++;
    tick();
    total++;
    if (bus.m_WGRNT !== 4'b0001) $display("FAIL lone_regrant got=%b want=0001", bus.m_WGRNT);
    else passed++;
    total++;
    if (dut.ptr_reg !== 2'd1) $display("FAIL lone_ptr got=%0d want=1", dut.ptr_reg);
    else passed++;
    total++;
    if (bus.m_WGRNT !== exp_grant()) $display("FAIL lone_model got=%b want=%b", bus.m_WGRNT, exp_grant());
    else passed++;
    bus.m_BVALID = 1'b0;
    bus.m_AWREADY = 1'b1;
    tick();
    bus.s_AWVALID = 4'b0000;
    bus.m_BVALID = 1'b1;
    tick();
    bus.m_BVALID = 1'b0;
    total++;
    if (bus.m_WGRNT !== 4'b0000) $display("FAIL lone_idle got=%b want=0000", bus.m_WGRNT);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.s_AWVALID = N'($urandom);
      bus.s_BREADY = N'($urandom);
      bus.m_AWREADY = ($urandom_range(0, 1) == 1);
      bus.m_BVALID = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      total++;
      if (bus.m_WGRNT !== exp_grant()) $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, bus.m_WGRNT, exp_grant());
      else passed++;
      total++;
      if (bus.m_AWEN !== exp_awen()) $display("FAIL rnd_awen cyc=%0d got=%b want=%b", cyc, bus.m_AWEN, exp_awen());
      else passed++;
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.s_AWVALID = '0;
    bus.s_BREADY = '0;
    bus.m_AWREADY = 1'b0;
    bus.m_BVALID = 1'b0;
    for (int i = 0; i < N; i++) quota[i] = 0;
    test_reset();
    test_rotation();
    test_outstanding_limit();
    test_simultaneous();
    test_fairness();
    test_lone_requester();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
